// File: rtl/im2col_addr_gen.sv
// im2col read-address generator for one convolution layer.
// Derives the output size (T-K)/S by repeated subtraction, then walks
// kx -> ky -> c -> ox -> oy, issuing one input-buffer address per handshake.
//
// state  | meaning
// S_IDLE | waiting for a 0->1 edge on start_conv
// S_CALC | one compare/subtract per cycle to find q = (T-K)/S
// S_PARA | n_ofs valid, n_para_done pulse, walk counters cleared
// S_WALK | addr_valid high, counters advance on each accepted address
// S_DONE | w_done pulse, back to idle
module im2col_addr_gen #(
  parameter int TENSOR_W = 8,
  parameter int KERNEL_W = 4,
  parameter int CHAN_W   = 8,
  parameter int STRIDE_W = 3,
  parameter int ADDR_W   = 16
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                start_conv,
  input  logic [TENSOR_W-1:0] tensor_size,
  input  logic [KERNEL_W-1:0] kernel_size,
  input  logic [CHAN_W-1:0]   channels,
  input  logic [STRIDE_W-1:0] stride,
  input  logic                addr_ready,
  output logic                addr_valid,
  output logic [ADDR_W-1:0]   rd_addr,
  output logic                col_last,
  output logic                n_para_done,
  output logic [TENSOR_W-1:0] n_ofs,
  output logic                w_done,
  output logic                param_err
);

  typedef enum logic [2:0] {S_IDLE, S_CALC, S_PARA, S_WALK, S_DONE} state_t;

  state_t r_state;
  state_t w_next;

  logic                r_start_prev;
  logic [TENSOR_W-1:0] r_t;
  logic [KERNEL_W-1:0] r_k;
  logic [CHAN_W-1:0]   r_c;
  logic [STRIDE_W-1:0] r_s;
  logic [ADDR_W-1:0]   r_tt;
  logic [TENSOR_W-1:0] r_rem;
  logic [TENSOR_W-1:0] r_q;
  logic [KERNEL_W-1:0] r_kx, r_ky;
  logic [CHAN_W-1:0]   r_ci;
  logic [TENSOR_W-1:0] r_ox, r_oy;
  logic [TENSOR_W-1:0] r_ox_base, r_oy_base;

  logic                w_start_edge;
  logic                w_bad;
  logic [TENSOR_W-1:0] w_s_ext;
  logic                w_calc_step;
  logic                w_kx_last, w_ky_last, w_c_last, w_ox_last, w_oy_last;
  logic                w_fire;
  logic                w_final;
  logic [ADDR_W-1:0]   w_chan_off, w_row, w_col;

  assign w_start_edge = start_conv & ~r_start_prev;
  assign w_bad        = (tensor_size < TENSOR_W'(kernel_size)) || (channels == '0);
  assign w_s_ext      = TENSOR_W'(r_s);
  assign w_calc_step  = (r_rem >= w_s_ext);

  assign w_kx_last = (r_kx == r_k - KERNEL_W'(1));
  assign w_ky_last = (r_ky == r_k - KERNEL_W'(1));
  assign w_c_last  = (r_ci == r_c - CHAN_W'(1));
  assign w_ox_last = (r_ox == r_q);
  assign w_oy_last = (r_oy == r_q);
  assign w_fire    = (r_state == S_WALK) && addr_ready;
  assign w_final   = w_kx_last & w_ky_last & w_c_last & w_ox_last & w_oy_last;

  // Address is a pure function of the registered counters, so it holds while stalled.
  assign w_chan_off = ADDR_W'(r_ci) * r_tt;
  assign w_row      = ADDR_W'(r_oy_base) + ADDR_W'(r_ky);
  assign w_col      = ADDR_W'(r_ox_base) + ADDR_W'(r_kx);
  assign rd_addr    = w_chan_off + w_row * ADDR_W'(r_t) + w_col;

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    w_next      = r_state;
    addr_valid  = 1'b0;
    n_para_done = 1'b0;
    w_done      = 1'b0;
    col_last    = 1'b0;
    case (r_state)
      S_IDLE: if (w_start_edge) w_next = w_bad ? S_DONE : S_CALC;
      S_CALC: if (!w_calc_step) w_next = S_PARA;
      S_PARA: begin
        n_para_done = 1'b1;
        w_next      = S_WALK;
      end
      S_WALK: begin
        addr_valid = 1'b1;
        col_last   = w_kx_last & w_ky_last & w_c_last;
        if (w_fire && w_final) w_next = S_DONE;
      end
      S_DONE: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Parameter latch, output-size division and walk counters.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_start_prev <= 1'b0;
      r_t          <= '0;
      r_k          <= '0;
      r_c          <= '0;
      r_s          <= '0;
      r_tt         <= '0;
      r_rem        <= '0;
      r_q          <= '0;
      r_kx         <= '0;
      r_ky         <= '0;
      r_ci         <= '0;
      r_ox         <= '0;
      r_oy         <= '0;
      r_ox_base    <= '0;
      r_oy_base    <= '0;
      n_ofs        <= '0;
      param_err    <= 1'b0;
    end else begin
      r_start_prev <= start_conv;
      case (r_state)
        S_IDLE: begin
          if (w_start_edge) begin
            r_t       <= tensor_size;
            r_k       <= kernel_size;
            r_c       <= channels;
            r_s       <= (stride == '0) ? STRIDE_W'(1) : stride;
            r_tt      <= ADDR_W'(tensor_size) * ADDR_W'(tensor_size);
            r_rem     <= tensor_size - TENSOR_W'(kernel_size);
            r_q       <= '0;
            param_err <= w_bad;
            if (w_bad) n_ofs <= '0;
          end
        end
        S_CALC: begin
          if (w_calc_step) begin
            r_rem <= r_rem - w_s_ext;
            r_q   <= r_q + TENSOR_W'(1);
          end else begin
            n_ofs <= r_q;
          end
        end
        S_PARA: begin
          r_kx      <= '0;
          r_ky      <= '0;
          r_ci      <= '0;
          r_ox      <= '0;
          r_oy      <= '0;
          r_ox_base <= '0;
          r_oy_base <= '0;
        end
        S_WALK: begin
          if (w_fire) begin
            r_kx <= w_kx_last ? '0 : r_kx + KERNEL_W'(1);
            if (w_kx_last) begin
              r_ky <= w_ky_last ? '0 : r_ky + KERNEL_W'(1);
              if (w_ky_last) begin
                r_ci <= w_c_last ? '0 : r_ci + CHAN_W'(1);
                if (w_c_last) begin
                  if (w_ox_last) begin
                    r_ox      <= '0;
                    r_ox_base <= '0;
                    if (w_oy_last) begin
                      r_oy      <= '0;
                      r_oy_base <= '0;
                    end else begin
                      r_oy      <= r_oy + TENSOR_W'(1);
                      r_oy_base <= r_oy_base + w_s_ext;
                    end
                  end else begin
                    r_ox      <= r_ox + TENSOR_W'(1);
                    r_ox_base <= r_ox_base + w_s_ext;
                  end
                end
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_im2col_addr_gen.sv
// Bench for im2col_addr_gen: table of layer cases, hand-checked address
// fragments, reset/restart sequences and random layers against a loop model.
module tb_im2col_addr_gen;

  localparam int TENSOR_W = 8;
  localparam int KERNEL_W = 4;
  localparam int CHAN_W   = 8;
  localparam int STRIDE_W = 3;
  localparam int ADDR_W   = 16;

  logic                clk = 1'b0;
  logic                rstn;
  logic                start_conv;
  logic [TENSOR_W-1:0] tensor_size;
  logic [KERNEL_W-1:0] kernel_size;
  logic [CHAN_W-1:0]   channels;
  logic [STRIDE_W-1:0] stride;
  logic                addr_ready;
  logic                addr_valid;
  logic [ADDR_W-1:0]   rd_addr;
  logic                col_last;
  logic                n_para_done;
  logic [TENSOR_W-1:0] n_ofs;
  logic                w_done;
  logic                param_err;

  im2col_addr_gen #(
    .TENSOR_W(TENSOR_W), .KERNEL_W(KERNEL_W), .CHAN_W(CHAN_W),
    .STRIDE_W(STRIDE_W), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rstn(rstn), .start_conv(start_conv),
    .tensor_size(tensor_size), .kernel_size(kernel_size),
    .channels(channels), .stride(stride), .addr_ready(addr_ready),
    .addr_valid(addr_valid), .rd_addr(rd_addr), .col_last(col_last),
    .n_para_done(n_para_done), .n_ofs(n_ofs), .w_done(w_done),
    .param_err(param_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int t, k, c, s;
    bit rand_rdy;
    int exp_nofs;
    bit exp_err;
    int exp_count;
  } vec_t;

  typedef struct {
    int addr;
    bit last;
  } elem_t;

  int n_vec = 0;
  int n_err = 0;
  int got_addr[$];

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Runs one layer from a fresh start edge and checks it end to end.
  task automatic run_layer(input int t, input int k, input int c, input int s,
                           input bit rand_rdy, input int exp_nofs,
                           input bit exp_err, input int exp_count,
                           input bit keep_start);
    elem_t q_exp[$];
    elem_t e;
    int se, mq, cyc, hs, last_hs_cyc, para_cyc, para_cnt, first_valid, done_cyc;
    int prev_addr, prev_last;
    bit done, prev_stall, rdy, merr;

    se   = (s == 0) ? 1 : s;
    merr = (t < k) || (c == 0);
    mq   = merr ? 0 : (t - k) / se;
    if (!merr)
      for (int oy = 0; oy <= mq; oy++)
        for (int ox = 0; ox <= mq; ox++)
          for (int ci = 0; ci < c; ci++)
            for (int ky = 0; ky < k; ky++)
              for (int kx = 0; kx < k; kx++) begin
                e.addr = (ci * t * t + (oy * se + ky) * t + ox * se + kx) & 32'hFFFF;
                e.last = (kx == k - 1) && (ky == k - 1) && (ci == c - 1);
                q_exp.push_back(e);
              end

    got_addr.delete();
    cyc = 0; hs = 0; last_hs_cyc = -1; para_cyc = -1; para_cnt = 0;
    first_valid = -1; done_cyc = -1; done = 0; prev_stall = 0;
    prev_addr = 0; prev_last = 0;

    @(negedge clk);
    tensor_size = TENSOR_W'(t);
    kernel_size = KERNEL_W'(k);
    channels    = CHAN_W'(c);
    stride      = STRIDE_W'(s);
    start_conv  = 1'b1;
    addr_ready  = 1'b0;

    while (!done && cyc < 20000) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (n_para_done) begin
        para_cnt++;
        para_cyc = cyc;
        chk("n_ofs_at_para", n_ofs, exp_nofs);
      end
      if (addr_valid && first_valid < 0) first_valid = cyc;
      if (prev_stall) begin
        chk("stall_valid", addr_valid, 1);
        chk("stall_addr", rd_addr, prev_addr);
        chk("stall_col_last", col_last, prev_last);
      end
      rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      addr_ready = rdy;
      if (addr_valid) begin
        if (rdy) begin
          hs++;
          last_hs_cyc = cyc;
          got_addr.push_back(int'(rd_addr));
          if (q_exp.size() > 0) begin
            e = q_exp.pop_front();
            chk("rd_addr", rd_addr, e.addr);
            chk("col_last", col_last, e.last);
          end else begin
            chk("addr_overrun", hs, exp_count);
          end
        end
        prev_stall = !rdy;
        prev_addr  = int'(rd_addr);
        prev_last  = int'(col_last);
      end else begin
        prev_stall = 1'b0;
      end
      if (w_done) begin
        done     = 1'b1;
        done_cyc = cyc;
      end
    end

    if (!done) chk("w_done_timeout", cyc, -1);
    chk("addr_count", hs, exp_count);
    chk("param_err", param_err, exp_err);
    chk("n_ofs_final", n_ofs, exp_nofs);
    if (!exp_err) begin
      chk("para_cycle", para_cyc, exp_nofs + 2);
      chk("para_count", para_cnt, 1);
      chk("first_valid_cycle", first_valid, exp_nofs + 3);
      chk("done_cycle", done_cyc, last_hs_cyc + 1);
    end else begin
      chk("err_done_cycle", done_cyc, 1);
      chk("err_para_count", para_cnt, 0);
      chk("err_valid_seen", first_valid, -1);
    end

    addr_ready = 1'b0;
    if (!keep_start) start_conv = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("w_done_one_cycle", w_done, 0);
    chk("idle_valid", addr_valid, 0);
  endtask

  vec_t tbl[7];
  int exp_t5[9]  = '{0, 1, 2, 5, 6, 7, 10, 11, 12};
  int exp_t7c1[9] = '{49, 50, 51, 56, 57, 58, 63, 64, 65};

  initial begin
    int events;
    int t, k, c, s, se, nofs, cnt;
    bit err;

    rstn = 1'b0;
    start_conv = 1'b0;
    tensor_size = '0; kernel_size = '0; channels = '0; stride = '0;
    addr_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_addr_valid", addr_valid, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_col_last", col_last, 0);
    chk("rst_n_para_done", n_para_done, 0);
    chk("rst_n_ofs", n_ofs, 0);
    chk("rst_w_done", w_done, 0);
    chk("rst_param_err", param_err, 0);
    rstn = 1'b1;
    @(negedge clk);

    //         t  k  c  s  rnd nofs err count
    tbl[0] = '{5, 3, 1, 1, 0,  2,   0,  81};
    tbl[1] = '{7, 3, 2, 2, 0,  2,   0,  162};
    tbl[2] = '{5, 3, 1, 1, 1,  2,   0,  81};
    tbl[3] = '{2, 3, 1, 1, 0,  0,   1,  0};
    tbl[4] = '{5, 3, 0, 1, 0,  0,   1,  0};
    tbl[5] = '{6, 2, 1, 0, 0,  4,   0,  100};
    tbl[6] = '{4, 4, 3, 3, 1,  0,   0,  48};

    for (int i = 0; i < 7; i++) begin
      run_layer(tbl[i].t, tbl[i].k, tbl[i].c, tbl[i].s, tbl[i].rand_rdy,
                tbl[i].exp_nofs, tbl[i].exp_err, tbl[i].exp_count, 1'b0);
      if ((i == 0 || i == 2) && got_addr.size() >= 9)
        for (int j = 0; j < 9; j++) chk("t5_first_addrs", got_addr[j], exp_t5[j]);
      if (i == 1 && got_addr.size() >= 19) begin
        for (int j = 0; j < 9; j++) chk("t7_col0_chan1", got_addr[9 + j], exp_t7c1[j]);
        chk("t7_col1_start", got_addr[18], 2);
      end
    end

    // Reset in the middle of a walk, then a fresh layer replays from 0.
    @(negedge clk);
    tensor_size = 8'd5; kernel_size = 4'd3; channels = 8'd1; stride = 3'd1;
    start_conv = 1'b1;
    addr_ready = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("pre_reset_walking", addr_valid, 1);
    rstn = 1'b0;
    start_conv = 1'b0;
    #1;
    chk("midrst_addr_valid", addr_valid, 0);
    chk("midrst_rd_addr", rd_addr, 0);
    chk("midrst_col_last", col_last, 0);
    chk("midrst_n_para_done", n_para_done, 0);
    chk("midrst_n_ofs", n_ofs, 0);
    chk("midrst_w_done", w_done, 0);
    chk("midrst_param_err", param_err, 0);
    @(negedge clk);
    rstn = 1'b1;
    addr_ready = 1'b0;
    @(negedge clk);
    run_layer(5, 3, 1, 1, 1'b0, 2, 1'b0, 81, 1'b0);
    if (got_addr.size() > 0) chk("replay_first_addr", got_addr[0], 0);

    // start_conv held high across w_done must not retrigger.
    run_layer(5, 3, 1, 1, 1'b0, 2, 1'b0, 81, 1'b1);
    events = 0;
    for (int j = 0; j < 10; j++) begin
      @(posedge clk);
      @(negedge clk);
      if (addr_valid || n_para_done || w_done) events++;
    end
    chk("no_retrigger", events, 0);
    start_conv = 1'b0;
    @(posedge clk);
    run_layer(4, 2, 2, 0, 1'b1, 2, 1'b0, 72, 1'b0);

    // Random layers against the loop model.
    for (int i = 0; i < 8; i++) begin
      t = $urandom_range(1, 9);
      k = $urandom_range(1, 3);
      c = $urandom_range(0, 2);
      s = $urandom_range(0, 4);
      se = (s == 0) ? 1 : s;
      err = (t < k) || (c == 0);
      nofs = err ? 0 : (t - k) / se;
      cnt = err ? 0 : (nofs + 1) * (nofs + 1) * c * k * k;
      run_layer(t, k, c, s, 1'b1, nofs, err, cnt, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
